// File: rtl/tlb_refill_pkg.sv
// Shared types for the TLB refill controller: FSM state encoding and the
// walker channel records.
package tlb_refill_pkg;

   // Widest supported translation scheme (Sv48 VPN, 64-bit PTE).
   localparam int VPN_BITS_MAX = 36;
   localparam int PTE_BITS_MAX = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      FAULT = 3'd4,
      DRAIN = 3'd5
   } refill_state_t;

   // Walk request record: the page to translate.
   typedef struct packed {
      logic [VPN_BITS_MAX-1:0] vpn;
   } walk_req_t;

   // Walk response record: leaf PTE plus fault flag (PTE ignored on fault).
   typedef struct packed {
      logic [PTE_BITS_MAX-1:0] pte;
      logic                    fault;
   } walk_rsp_t;

endpackage

// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: turns a lookup miss into one page-table walk and a
// single-cycle TLB write (or a fault pulse). A flush at any point cancels the
// install while still absorbing the walker's outstanding response.
module tlb_refill_ctrl
   import tlb_refill_pkg::*;
#(
   parameter int VPN_BITS = 27,
   parameter int PTE_BITS = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                TLBMiss,
   input  logic                TLBFlush,
   input  logic [VPN_BITS-1:0] MissVPN,
   output logic                WalkReqValid,
   input  logic                WalkReqReady,
   output logic [VPN_BITS-1:0] WalkReqVPN,
   input  logic                WalkRspValid,
   output logic                WalkRspReady,
   input  logic [PTE_BITS-1:0] WalkRspPTE,
   input  logic                WalkRspFault,
   output logic                TLBWrite,
   output logic [VPN_BITS-1:0] TLBWriteVPN,
   output logic [PTE_BITS-1:0] TLBWritePTE,
   output logic                PageFault,
   output logic                Busy
);

   refill_state_t       state_q;
   logic [VPN_BITS-1:0] vpn_q;      // VPN of the refill in flight
   logic [VPN_BITS-1:0] wr_vpn_q;   // tag presented to the TLB, held between writes
   logic [PTE_BITS-1:0] pte_q;      // PTE presented to the TLB, held between writes
   logic                flush_pend_q;

   // Refill FSM with its capture registers; every path back to IDLE clears the pending flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         vpn_q        <= '0;
         wr_vpn_q     <= '0;
         pte_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               flush_pend_q <= 1'b0;
               if (TLBMiss && !TLBFlush) begin
                  vpn_q   <= MissVPN;
                  state_q <= REQ;
               end
            end
            REQ: begin
               // The request stays valid until accepted; a flush only redirects where it ends up.
               if (TLBFlush) flush_pend_q <= 1'b1;
               if (WalkReqReady) begin
                  state_q <= (flush_pend_q || TLBFlush) ? DRAIN : WAIT;
               end
            end
            WAIT: begin
               if (WalkRspValid) begin
                  if (TLBFlush) begin
                     flush_pend_q <= 1'b0;
                     state_q      <= IDLE;
                  end else if (WalkRspFault) begin
                     state_q <= FAULT;
                  end else begin
                     pte_q    <= WalkRspPTE;
                     wr_vpn_q <= vpn_q;
                     state_q  <= WRITE;
                  end
               end else if (TLBFlush) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (WalkRspValid) begin
                  flush_pend_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            WRITE, FAULT: begin
               flush_pend_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               flush_pend_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   // Moore decode of the state register; only the install/fault strobes are masked by a flush.
   assign WalkReqValid = (state_q == REQ);
   assign WalkReqVPN   = vpn_q;
   assign WalkRspReady = (state_q == WAIT) || (state_q == DRAIN);
   assign TLBWrite     = (state_q == WRITE) && !TLBFlush;
   assign TLBWriteVPN  = wr_vpn_q;
   assign TLBWritePTE  = pte_q;
   assign PageFault    = (state_q == FAULT) && !TLBFlush;
   assign Busy         = (state_q != IDLE);

endmodule
